// File: rtl/ktms_fc_pkg.sv
// Shared definitions for the FC completion path: status override code, counter sizing, request-stage states.
package ktms_fc_pkg;

    // Status reported in place of the native one whenever an error was recorded for the tag.
    localparam logic [63:0] ERR_OVR_STAT = '1;

    function automatic int outst_cnt_width(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    typedef enum logic {
        REQ_EMPTY = 1'b0,
        REQ_FULL  = 1'b1
    } req_state_e;

endpackage

// File: rtl/ktms_fc_cmpl_if.sv
// Handshake bundle of ktms_fc_cmpl: completion in, error-store read/return, completion record out.
// o_errcnt exists only when KTMS_FC_CMPL_ERRCNT_EN is defined.
interface ktms_fc_cmpl_if #(
    parameter int tag_width     = 1,
    parameter int tag_par_width = 1,
    parameter int width         = 1,
    parameter int stat_width    = 8
);
    localparam int tag_width_w_par = tag_width + tag_par_width;

    logic                       i_cmpl_v;
    logic                       i_cmpl_r;
    logic [tag_width_w_par-1:0] i_cmpl_tag;
    logic [stat_width-1:0]      i_cmpl_stat;

    logic                       er_rd_v;
    logic                       er_rd_r;
    logic [tag_width_w_par-1:0] er_rd_tag;
    logic [stat_width-1:0]      er_rd_aux;

    logic                       er_v;
    logic                       er_r;
    logic                       er_dv;
    logic [width-1:0]           er_d;
    logic [stat_width-1:0]      er_aux;
    logic [tag_width_w_par-1:0] er_tag;

    logic                       o_v;
    logic                       o_r;
    logic [tag_width_w_par-1:0] o_tag;
    logic                       o_err;
    logic [stat_width-1:0]      o_stat;
    logic [width-1:0]           o_edata;
    logic                       o_perror;
`ifdef KTMS_FC_CMPL_ERRCNT_EN
    logic [31:0]                o_errcnt;

    modport slave (
        input  i_cmpl_v, i_cmpl_tag, i_cmpl_stat, output i_cmpl_r,
        output er_rd_v, er_rd_tag, er_rd_aux, input er_rd_r,
        input  er_v, er_dv, er_d, er_aux, er_tag, output er_r,
        output o_v, o_tag, o_err, o_stat, o_edata, o_perror, o_errcnt, input o_r
    );
    modport master (
        output i_cmpl_v, i_cmpl_tag, i_cmpl_stat, input i_cmpl_r,
        input  er_rd_v, er_rd_tag, er_rd_aux, output er_rd_r,
        output er_v, er_dv, er_d, er_aux, er_tag, input er_r,
        input  o_v, o_tag, o_err, o_stat, o_edata, o_perror, o_errcnt, output o_r
    );
`else
    modport slave (
        input  i_cmpl_v, i_cmpl_tag, i_cmpl_stat, output i_cmpl_r,
        output er_rd_v, er_rd_tag, er_rd_aux, input er_rd_r,
        input  er_v, er_dv, er_d, er_aux, er_tag, output er_r,
        output o_v, o_tag, o_err, o_stat, o_edata, o_perror, input o_r
    );
    modport master (
        output i_cmpl_v, i_cmpl_tag, i_cmpl_stat, input i_cmpl_r,
        input  er_rd_v, er_rd_tag, er_rd_aux, output er_rd_r,
        output er_v, er_dv, er_d, er_aux, er_tag, input er_r,
        input  o_v, o_tag, o_err, o_stat, o_edata, o_perror, output o_r
    );
`endif
endinterface

// File: rtl/capi_parcheck.sv
// Odd-parity checker: flags (one cycle later) a qualified word whose parity bit does not make the total odd.
module capi_parcheck #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] data,
    input  logic             datap,
    input  logic             check,
    output logic             parerr
);
    logic parerr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            parerr_reg <= 1'b0;
        end else begin
            parerr_reg <= check & (datap != ~(^data));
        end
    end

    assign parerr = parerr_reg;
endmodule

// File: rtl/ktms_fc_cmpl_skid.sv
// Two-entry in-order output buffer; wr_r depends only on occupancy so the upstream sees no combinational path from rd_r.
module ktms_fc_cmpl_skid #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_v,
    output logic          wr_r,
    input  logic [dw-1:0] wr_d,
    output logic          rd_v,
    input  logic          rd_r,
    output logic [dw-1:0] rd_d
);
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] cnt_reg;
    logic       wr_hs;
    logic       rd_hs;

    assign wr_r  = (cnt_reg != 2'd2);
    assign rd_v  = (cnt_reg != 2'd0);
    assign wr_hs = wr_v & wr_r;
    assign rd_hs = rd_v & rd_r;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ent
        logic [dw-1:0] ent_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                ent_reg <= '0;
            end else if (wr_hs && (wr_ptr_reg == 1'(gi))) begin
                ent_reg <= wr_d;
            end
        end
    end

    assign rd_d = rd_ptr_reg ? g_ent[1].ent_reg : g_ent[0].ent_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else begin
            if (wr_hs) wr_ptr_reg <= ~wr_ptr_reg;
            if (rd_hs) rd_ptr_reg <= ~rd_ptr_reg;
            if (wr_hs && !rd_hs)      cnt_reg <= cnt_reg + 2'd1;
            else if (!wr_hs && rd_hs) cnt_reg <= cnt_reg - 2'd1;
        end
    end
endmodule

// File: rtl/ktms_fc_cmpl.sv
// Completion merge: reads the per-tag error store for each completing tag and emits one merged record per tag.
// Define KTMS_FC_CMPL_ERRCNT_EN to add the saturating o_errcnt error counter.
module ktms_fc_cmpl
    import ktms_fc_pkg::*;
#(
    parameter int tag_width     = 1,
    parameter int tag_par_width = 1,
    parameter int width         = 1,
    parameter int stat_width    = 8,
    parameter int max_outst     = 4
) (
    input  logic           clk,
    input  logic           reset,
    ktms_fc_cmpl_if.slave  bus
);
    localparam int tag_width_w_par = tag_width + tag_par_width;
    localparam int cnt_width       = outst_cnt_width(max_outst);
    // Record layout in the skid buffer: {tag, err, stat, edata}
    localparam int stat_lsb  = width;
    localparam int err_bit   = width + stat_width;
    localparam int tag_lsb   = err_bit + 1;
    localparam int rec_width = tag_lsb + tag_width_w_par;

    req_state_e                 req_state_reg, req_state_next;
    logic [tag_width_w_par-1:0] req_tag_reg;
    logic [stat_width-1:0]      req_stat_reg;
    logic [cnt_width-1:0]       outst_cnt_reg, outst_cnt_next;

    logic cnt_ok;
    logic cmpl_acc;
    logic rd_hs;
    logic er_hs;
    logic o_hs;

    // ---------------- request stage ----------------
    assign cnt_ok        = (outst_cnt_reg < cnt_width'(max_outst));
    assign bus.er_rd_v   = (req_state_reg == REQ_FULL) & cnt_ok;
    assign rd_hs         = bus.er_rd_v & bus.er_rd_r;
    assign bus.i_cmpl_r  = (req_state_reg == REQ_EMPTY) | rd_hs;
    assign cmpl_acc      = bus.i_cmpl_v & bus.i_cmpl_r;
    assign bus.er_rd_tag = req_tag_reg;
    assign bus.er_rd_aux = req_stat_reg;

    always_comb begin
        req_state_next = req_state_reg;
        if (cmpl_acc) begin
            req_state_next = REQ_FULL;
        end else if (rd_hs) begin
            req_state_next = REQ_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_state_reg <= REQ_EMPTY;
            req_tag_reg   <= '0;
            req_stat_reg  <= '0;
        end else begin
            req_state_reg <= req_state_next;
            if (cmpl_acc) begin
                req_tag_reg  <= bus.i_cmpl_tag;
                req_stat_reg <= bus.i_cmpl_stat;
            end
        end
    end

    // ---------------- outstanding-read accounting ----------------
    // A read stays counted until its merged record leaves, which bounds skid + store occupancy.
    always_comb begin
        outst_cnt_next = outst_cnt_reg;
        if (rd_hs && !o_hs && (outst_cnt_reg != cnt_width'(max_outst))) begin
            outst_cnt_next = outst_cnt_reg + 1'b1;
        end else if (!rd_hs && o_hs && (outst_cnt_reg != '0)) begin
            outst_cnt_next = outst_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_cnt_reg <= '0;
        end else begin
            outst_cnt_reg <= outst_cnt_next;
        end
    end

    // ---------------- merge + output buffer ----------------
    logic [stat_width-1:0] stat_merged;
    logic [width-1:0]      edata_merged;
    logic [rec_width-1:0]  rec_in;
    logic [rec_width-1:0]  rec_out;

    assign stat_merged  = bus.er_dv ? ERR_OVR_STAT[stat_width-1:0] : bus.er_aux;
    assign edata_merged = bus.er_dv ? bus.er_d : '0;
    assign rec_in       = {bus.er_tag, bus.er_dv, stat_merged, edata_merged};
    assign er_hs        = bus.er_v & bus.er_r;
    assign o_hs         = bus.o_v & bus.o_r;

    ktms_fc_cmpl_skid #(
        .dw(rec_width)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .wr_v  (bus.er_v),
        .wr_r  (bus.er_r),
        .wr_d  (rec_in),
        .rd_v  (bus.o_v),
        .rd_r  (bus.o_r),
        .rd_d  (rec_out)
    );

    assign bus.o_edata = rec_out[stat_lsb-1:0];
    assign bus.o_stat  = rec_out[err_bit-1:stat_lsb];
    assign bus.o_err   = rec_out[err_bit];
    assign bus.o_tag   = rec_out[rec_width-1:tag_lsb];

    // ---------------- parity (tag parity sits in bit 0) ----------------
    logic perr_in;
    logic perr_er;
    logic perror_reg;

    capi_parcheck #(
        .width(tag_width)
    ) u_pc_in (
        .clk    (clk),
        .reset  (reset),
        .data   (bus.i_cmpl_tag[tag_width_w_par-1:tag_par_width]),
        .datap  (bus.i_cmpl_tag[0]),
        .check  (cmpl_acc),
        .parerr (perr_in)
    );

    capi_parcheck #(
        .width(tag_width)
    ) u_pc_er (
        .clk    (clk),
        .reset  (reset),
        .data   (bus.er_tag[tag_width_w_par-1:tag_par_width]),
        .datap  (bus.er_tag[0]),
        .check  (er_hs),
        .parerr (perr_er)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            perror_reg <= 1'b0;
        end else if (perr_in || perr_er) begin
            perror_reg <= 1'b1;
        end
    end

    assign bus.o_perror = perror_reg;

`ifdef KTMS_FC_CMPL_ERRCNT_EN
    logic [31:0] errcnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            errcnt_reg <= '0;
        end else if (o_hs && bus.o_err && (errcnt_reg != 32'hFFFF_FFFF)) begin
            errcnt_reg <= errcnt_reg + 32'd1;
        end
    end

    assign bus.o_errcnt = errcnt_reg;
`endif

endmodule

// File: tb/tb_ktms_fc_cmpl.sv
// Directed bench for ktms_fc_cmpl with an in-order error-store model and an expected-record scoreboard.
module tb_ktms_fc_cmpl;
    localparam int TW  = 4;
    localparam int TPW = 1;
    localparam int TWP = TW + TPW;
    localparam int W   = 4;
    localparam int SW  = 8;
    localparam int MO  = 4;

    typedef struct packed {
        logic [TWP-1:0] tag;
        logic [SW-1:0]  stat;
        logic           dv;
        logic [W-1:0]   d;
    } item_t;

    typedef struct packed {
        logic [TWP-1:0] tag;
        logic           err;
        logic [SW-1:0]  stat;
        logic [W-1:0]   edata;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ktms_fc_cmpl_if #(.tag_width(TW), .tag_par_width(TPW), .width(W), .stat_width(SW)) bus ();

    ktms_fc_cmpl #(
        .tag_width(TW), .tag_par_width(TPW), .width(W), .stat_width(SW), .max_outst(MO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    item_t stim_q[$];
    item_t side_q[$];
    item_t store_q[$];
    rec_t  exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int sim_cnt = 0;
    int max_cnt = 0;
    int bad_cyc = -1;
    int perr_cyc = -1;
    bit store_hold = 0;
    bit o_r_ctl = 1;
    bit in_f, rd_f, er_f, o_f;
    logic [TWP-1:0] rd_tag_s;
    logic [SW-1:0]  rd_aux_s;
    int cnt_s;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [TWP-1:0] mk_tag(input int t, input bit bad);
        logic [TW-1:0] tv;
        tv = TW'(t);
        return {tv, (~(^tv)) ^ bad};
    endfunction

    function automatic bit par_bad(input logic [TWP-1:0] t);
        return t[0] != ~(^t[TWP-1:1]);
    endfunction

    task automatic push(input int t, input int s, input bit dv, input int d, input bit bad);
        item_t it;
        rec_t  e;
        it.tag  = mk_tag(t, bad);
        it.stat = SW'(s);
        it.dv   = dv;
        it.d    = W'(d);
        stim_q.push_back(it);
        e.tag   = it.tag;
        e.err   = dv;
        e.stat  = dv ? {SW{1'b1}} : it.stat;
        e.edata = dv ? it.d : '0;
        exp_q.push_back(e);
    endtask

    // One clock: apply last cycle's handshakes to the models, drive inputs, then sample at the falling edge.
    task automatic step();
        item_t it;
        rec_t  e;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_f && o_f) begin
            check("sim_cnt", 64'(dut.outst_cnt_reg), 64'(cnt_s));
            sim_cnt++;
        end
        if (rd_f) begin
            if (side_q.size() == 0) check("spurious_rd", 1, 0);
            else begin
                it = side_q.pop_front();
                it.tag  = rd_tag_s;
                it.stat = rd_aux_s;
                store_q.push_back(it);
            end
            rd_cnt++;
        end
        if (in_f) side_q.push_back(stim_q.pop_front());
        if (er_f) void'(store_q.pop_front());

        bus.i_cmpl_v = (stim_q.size() != 0);
        if (stim_q.size() != 0) begin
            bus.i_cmpl_tag  = stim_q[0].tag;
            bus.i_cmpl_stat = stim_q[0].stat;
        end
        bus.er_v = !store_hold && (store_q.size() != 0);
        if (store_q.size() != 0) begin
            bus.er_tag = store_q[0].tag;
            bus.er_aux = store_q[0].stat;
            bus.er_dv  = store_q[0].dv;
            bus.er_d   = store_q[0].d;
        end
        bus.o_r = o_r_ctl;

        @(negedge clk);
        in_f     = bus.i_cmpl_v & bus.i_cmpl_r;
        rd_f     = bus.er_rd_v & bus.er_rd_r;
        er_f     = bus.er_v & bus.er_r;
        o_f      = bus.o_v & bus.o_r;
        rd_tag_s = bus.er_rd_tag;
        rd_aux_s = bus.er_rd_aux;
        cnt_s    = int'(dut.outst_cnt_reg);
        if (cnt_s > max_cnt) max_cnt = cnt_s;
        if (in_f && par_bad(bus.i_cmpl_tag) && bad_cyc < 0) bad_cyc = cyc;
        if (bus.o_perror && perr_cyc < 0) perr_cyc = cyc;
        if (o_f) begin
            if (exp_q.size() == 0) check("unexpected_o", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("o_rec", 64'({bus.o_tag, bus.o_err, bus.o_stat, bus.o_edata}), 64'(e));
                $display("cyc %0d: out tag=%0h err=%0b stat=%0h edata=%0h", cyc, bus.o_tag,
                         bus.o_err, bus.o_stat, bus.o_edata);
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || stim_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 64'(exp_q.size()), 0);
        step();
        step();
    endtask

    task automatic clear_bench();
        stim_q.delete();
        side_q.delete();
        store_q.delete();
        exp_q.delete();
        in_f = 0; rd_f = 0; er_f = 0; o_f = 0;
        bus.i_cmpl_v = 0; bus.er_v = 0;
        bus.i_cmpl_tag = '0; bus.i_cmpl_stat = '0;
        bus.er_tag = '0; bus.er_aux = '0; bus.er_dv = 0; bus.er_d = '0;
    endtask

    initial begin
        int rd_base;
        int n;
        reset = 1'b1;
        clear_bench();
        bus.er_rd_r = 1'b1;
        bus.o_r = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_cmpl_r", 64'(bus.i_cmpl_r), 1);
        check("rst_er_rd_v", 64'(bus.er_rd_v), 0);
        check("rst_er_r", 64'(bus.er_r), 1);
        check("rst_o_v", 64'(bus.o_v), 0);
        check("rst_o_fields", 64'({bus.o_tag, bus.o_err, bus.o_stat, bus.o_edata}), 0);
        check("rst_o_perror", 64'(bus.o_perror), 0);
        check("rst_outst", 64'(dut.outst_cnt_reg), 0);
`ifdef KTMS_FC_CMPL_ERRCNT_EN
        check("rst_errcnt", 64'(bus.o_errcnt), 0);
`endif
        reset = 1'b0;

        // clean completion, then one with a recorded error
        push(3, 8'h05, 0, 0, 0);
        drain("t1");
        push(7, 8'h42, 1, 2, 0);
        drain("t2");
`ifdef KTMS_FC_CMPL_ERRCNT_EN
        check("errcnt_one", 64'(bus.o_errcnt), 1);
`endif

        // output blocked: reads must stop at max_outst
        o_r_ctl = 0;
        rd_base = rd_cnt;
        for (int i = 0; i < 10; i++) push(i + 1, 8'h10 + i, (i % 3) == 0, i, 0);
        repeat (30) step();
        check("stall_rd_hs", 64'(rd_cnt - rd_base), MO);
        check("stall_cnt", 64'(dut.outst_cnt_reg), MO);
        check("stall_er_rd_v", 64'(bus.er_rd_v), 0);
        check("stall_i_cmpl_r", 64'(bus.i_cmpl_r), 0);
        check("stall_o_v", 64'(bus.o_v), 1);

        // release one record: count drops, exactly one more read, then stalled again
        o_r_ctl = 1;
        step();
        o_r_ctl = 0;
        step();
        check("one_out_cnt", 64'(dut.outst_cnt_reg), MO - 1);
        step();
        check("refill_cnt", 64'(dut.outst_cnt_reg), MO);
        check("refill_rd_hs", 64'(rd_cnt - rd_base), MO + 1);
        step();
        check("no_extra_rd", 64'(rd_cnt - rd_base), MO + 1);

        o_r_ctl = 1;
        drain("t3");
        check("max_cnt", 64'(max_cnt), MO);
        check("sim_seen", 64'(sim_cnt > 0), 1);
        check("t3_cnt_zero", 64'(dut.outst_cnt_reg), 0);
        check("t3_perror", 64'(bus.o_perror), 0);

        // bad tag parity: forwarded unchanged, sticky flag two cycles after acceptance
        push(5, 8'h33, 0, 0, 1);
        drain("t5");
        check("perr_delay", 64'(perr_cyc - bad_cyc), 2);
        push(2, 8'h21, 1, 9, 0);
        drain("t5b");
        check("perr_sticky", 64'(bus.o_perror), 1);

        // reset with three reads in flight
        store_hold = 1;
        rd_base = rd_cnt;
        push(1, 8'h01, 0, 0, 0);
        push(4, 8'h02, 1, 3, 0);
        push(6, 8'h03, 0, 0, 0);
        n = 0;
        while ((rd_cnt - rd_base) < 3 && n < 50) begin
            step();
            n++;
        end
        check("rst_inflight_rd", 64'(rd_cnt - rd_base), 3);
        check("rst_inflight_cnt", 64'(dut.outst_cnt_reg), 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_bench();
        store_hold = 0;
        @(posedge clk);
        #1;
        check("mid_rst_o_v", 64'(bus.o_v), 0);
        check("mid_rst_cnt", 64'(dut.outst_cnt_reg), 0);
        check("mid_rst_i_cmpl_r", 64'(bus.i_cmpl_r), 1);
        check("mid_rst_perror", 64'(bus.o_perror), 0);
`ifdef KTMS_FC_CMPL_ERRCNT_EN
        check("mid_rst_errcnt", 64'(bus.o_errcnt), 0);
`endif
        reset = 1'b0;

        push(3, 8'h05, 0, 0, 0);
        drain("t_recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
